// File: rtl/general_fifo_pkg.sv
// general_fifo_pkg: sizing and pointer-wrap helpers shared by the sync FIFO files.
package general_fifo_pkg;
  function automatic int fifo_ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction
  function automatic int fifo_cnt_width(input int depth);
    return fifo_ptr_width(depth) + 1;
  endfunction
  // Explicit wrap so depths that are not a power of two stay in range.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/general_sync_fifo_mem.sv
// general_sync_fifo_mem: 1W1R flop array, synchronous write, asynchronous read, no data reset.
module general_sync_fifo_mem #(
  parameter int DAT_WIDTH = 32,
  parameter int NUM_OF_ENTRIES = 16,
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DAT_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DAT_WIDTH-1:0] rdata
);
  logic [DAT_WIDTH-1:0] mem [NUM_OF_ENTRIES];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/general_sync_fifo_env.sv
// general_sync_fifo_env: single-clock FIFO with free depth, FWFT/registered read,
// almost flags, flush, error pulses and occupancy high-watermark.
module general_sync_fifo_env
  import general_fifo_pkg::*;
#(
  parameter int DAT_WIDTH = 32,
  parameter int NUM_OF_ENTRIES = 16,
  parameter int PTR_WIDTH = fifo_ptr_width(NUM_OF_ENTRIES),
  parameter bit FWFT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_op,
  input  logic [DAT_WIDTH-1:0] wr_data,
  input  logic                 rd_op,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  input  logic [PTR_WIDTH:0]   af_thr,
  input  logic [PTR_WIDTH:0]   ae_thr,
  output logic [PTR_WIDTH:0]   entry_used,
  output logic [PTR_WIDTH:0]   high_wmark,
  output logic                 wr_full_err,
  output logic                 rd_empty_err
);
  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(NUM_OF_ENTRIES);
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, next_cnt;
  logic [DAT_WIDTH-1:0] mem_rd, rd_q;
  logic push_acc, pop_acc;
  assign full = cnt == DEPTH_C;
  assign empty = cnt == '0;
  assign almost_full = cnt >= af_thr;
  assign almost_empty = cnt <= ae_thr;
  assign entry_used = cnt;
  assign pop_acc = rd_op && !empty;
  assign push_acc = wr_op && (!full || pop_acc);
  always_comb
    next_cnt = (push_acc && !pop_acc) ? cnt + CW'(1) :
               (pop_acc && !push_acc) ? cnt - CW'(1) : cnt;
  // Empty FWFT output is masked so it reads 0 out of reset rather than stale storage.
  assign rd_data = FWFT ? (empty ? '0 : mem_rd) : rd_q;
  general_sync_fifo_mem #(
    .DAT_WIDTH(DAT_WIDTH),
    .NUM_OF_ENTRIES(NUM_OF_ENTRIES),
    .AW(PTR_WIDTH)
  ) u_mem (
    .clk(clk),
    .we(push_acc && !flush),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(mem_rd)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      high_wmark <= '0;
      rd_q <= '0;
      wr_full_err <= 1'b0;
      rd_empty_err <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      high_wmark <= '0;
      wr_full_err <= 1'b0;
      rd_empty_err <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= PTR_WIDTH'(next_ptr(int'(wr_ptr), NUM_OF_ENTRIES));
      if (pop_acc) rd_ptr <= PTR_WIDTH'(next_ptr(int'(rd_ptr), NUM_OF_ENTRIES));
      if (pop_acc && !FWFT) rd_q <= mem_rd;
      cnt <= next_cnt;
      high_wmark <= (next_cnt > high_wmark) ? next_cnt : high_wmark;
      wr_full_err <= wr_op && !push_acc;
      rd_empty_err <= rd_op && !pop_acc;
    end
endmodule

// File: doc/general_sync_fifo_env.md
Name: general_sync_fifo_env

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO envelopes.
- Generalised in three ways:
  - width and depth are free; depth need not be a power of two;
  - read mode is selectable: first-word-fall-through or registered;
  - adds programmable almost-full/almost-empty thresholds, synchronous flush, error pulses and an occupancy high-watermark.
- Used for intra-domain buffering in front of stream consumers, where no CDC is needed.

Parameters:
DAT_WIDTH, 32, data bus width
NUM_OF_ENTRIES, 16, FIFO depth, any value >= 2
PTR_WIDTH, $clog2(NUM_OF_ENTRIES), address width (derived; do not override)
FWFT, 1, 1 = rd_data shows the head entry whenever not empty; 0 = rd_data is registered one cycle after rd_op

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous reset, active-high
flush  input  1  synchronous clear of contents
wr_op  input  1  push request
wr_data  input  DAT_WIDTH  push data
rd_op  input  1  pop request
rd_data  output  DAT_WIDTH  read data
full  output  1  count == NUM_OF_ENTRIES
empty  output  1  count == 0
almost_full  output  1  count >= af_thr
almost_empty  output  1  count <= ae_thr
af_thr  input  PTR_WIDTH+1  almost-full threshold (quasi-static)
ae_thr  input  PTR_WIDTH+1  almost-empty threshold (quasi-static)
entry_used  output  PTR_WIDTH+1  current occupancy
high_wmark  output  PTR_WIDTH+1  maximum occupancy since reset/flush
wr_full_err  output  1  one-cycle pulse: rejected push
rd_empty_err  output  1  one-cycle pulse: rejected pop

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all pointers, entry_used, high_wmark, rd_data and both err pulses go to 0. empty=1, full=0. almost_* are the combinational compares against count=0. Storage contents are not reset.
- Pointers: wr_ptr and rd_ptr count 0..NUM_OF_ENTRIES-1, then wrap to 0 explicitly (no power-of-two assumption).
- Count: a register of width PTR_WIDTH+1. Updates per cycle are +1 for push-only, -1 for pop-only, and 0 for both or neither.
- Accepted push: wr_op && (!full || pop_acc).
- Accepted pop (pop_acc): rd_op && !empty.
  - When full, a simultaneous push+pop is accepted: count is unchanged and both pointers advance.
  - When empty, a simultaneous push+pop accepts only the push. rd_empty_err pulses and count becomes 1.
- Error pulses:
  - wr_full_err is registered and high in the cycle after a rejected push.
  - rd_empty_err is registered and high in the cycle after a rejected pop.
  - Rejected ops change no state.
- FWFT=1: rd_data = mem[rd_ptr], combinational from registered state. A pushed word is visible the cycle after the push, which is when empty deasserts. rd_data is don't-care while empty.
- FWFT=0: on an accepted pop, rd_data <= mem[rd_ptr] (one-cycle latency). Otherwise rd_data holds its value.
- Flag derivation: full, empty, almost_* and entry_used are all derived from the count register, so they change the cycle after the causing op.
- Thresholds: af_thr=0 means almost_full is always asserted. ae_thr >= NUM_OF_ENTRIES means almost_empty is always asserted. Both are legal.
- high_wmark: updated to max(high_wmark, next_count) every cycle, so it is valid the same cycle as entry_used.
- Flush: pointers, count and high_wmark go to 0 and no error pulse is produced. Flush has priority over wr_op and rd_op in the same cycle; those ops are ignored without errors. rd_data is not cleared in FWFT=0.
- Reset asserted mid-operation: state returns to the reset values immediately; no partial write is guaranteed.

Decomposition:
- Package general_fifo_pkg:
  - fifo_ptr_width(depth) function (clog2, minimum 1);
  - fifo_cnt_width(depth) = ptr+1;
  - next_ptr wrap helper constant/function.
- Sub-module general_sync_fifo_mem:
  - 1W1R flop array, NUM_OF_ENTRIES x DAT_WIDTH;
  - synchronous write, asynchronous read;
  - no reset on data.
- Control (pointers, count, flags, watermark, errors, FWFT mux/register) stays in general_sync_fifo_env.

Test Plan:
- Depth 5, FWFT=1, af_thr=4, ae_thr=1:
  - stimulus: push 0xA1..0xA5 on consecutive cycles;
  - required response: almost_full rises after the 4th push and full after the 5th; a 6th push gives wr_full_err=1 for one cycle and entry_used stays 5.
- Wrap:
  - stimulus: depth 5, push/pop 13 words with a 2-entry steady occupancy;
  - required response: data out in order 1..13 with no errors; pointers wrap at 4->0.
- Full with simultaneous push+pop:
  - stimulus: push+pop while full;
  - required response: head word is popped, new word is stored at tail, entry_used stays 5, no error.
- Empty with simultaneous push+pop:
  - required response: rd_empty_err pulses, entry_used=1, and the pushed word is readable next cycle.
- FWFT=0:
  - stimulus: push 0x11, 0x22, then pop, pop;
  - required response: rd_data=0x11 one cycle after the first pop and 0x22 one cycle after the second; rd_data holds when no pop.
- Flush and reset:
  - stimulus: fill to 3 (high_wmark=3), then flush together with wr_op;
  - required response: entry_used=0, empty=1, high_wmark=0, no error pulse.
  - stimulus: assert reset asynchronously mid-burst;
  - required response: all outputs return to reset values before the next clock edge.
